// File: rtl/cpu_control_seq_pkg.sv
// Shared types and constants for the Simple RISC Machine control sequencer:
// state encoding, datapath strobe codes, instruction decode and per-state outputs.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST   = 5'd0,
    S_WAIT  = 5'd1,
    S_IF1   = 5'd2,
    S_IF2   = 5'd3,
    S_UPC   = 5'd4,
    S_DEC   = 5'd5,
    S_MOVI  = 5'd6,
    S_GETB  = 5'd7,
    S_GETA  = 5'd8,
    S_ALU   = 5'd9,
    S_ALUZ  = 5'd10,
    S_CMP   = 5'd11,
    S_WB    = 5'd12,
    S_ADDR  = 5'd13,
    S_LADDR = 5'd14,
    S_MRD   = 5'd15,
    S_LDWB  = 5'd16,
    S_STB   = 5'd17,
    S_STC   = 5'd18,
    S_MWR   = 5'd19,
    S_DONE  = 5'd20,
    S_HALT  = 5'd21
  } state_t;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_RD   = 2'b01;
  localparam logic [1:0] MEM_WR   = 2'b10;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] OP_MEM  = 2'b00;

  typedef struct packed {
    logic       w;
    logic       halted;
    logic [1:0] mem_cmd;
    logic       addr_sel;
    logic       load_addr;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [2:0] nsel;
  } ctrl_out_t;

  // Successor of S_DEC; anything undefined (including X) lands on S_DONE.
  function automatic state_t dec_next(input logic [2:0] opc, input logic [1:0] opv);
    state_t nx;
    nx = S_DONE;
    case (opc)
      OPC_MOV: begin
        case (opv)
          OP_MOVI: nx = S_MOVI;
          OP_MOVR: nx = S_GETB;
          default: nx = S_DONE;
        endcase
      end
      OPC_ALU: begin
        case (opv)
          OP_ADD, OP_CMP, OP_AND, OP_MVN: nx = S_GETB;
          default: nx = S_DONE;
        endcase
      end
      OPC_LDR, OPC_STR: begin
        case (opv)
          OP_MEM:  nx = S_GETA;
          default: nx = S_DONE;
        endcase
      end
      OPC_HALT: nx = S_HALT;
      default:  nx = S_DONE;
    endcase
    return nx;
  endfunction

  function automatic logic is_illegal(input logic [2:0] opc, input logic [1:0] opv);
    return (dec_next(opc, opv) == S_DONE);
  endfunction

  // Moore output decode; every field not set for a state stays zero.
  function automatic ctrl_out_t state_outputs(input state_t st);
    ctrl_out_t o;
    o = '0;
    case (st)
      S_RST:   begin o.reset_pc = 1'b1; o.load_pc = 1'b1; end
      S_WAIT:  o.w = 1'b1;
      S_IF1:   begin o.addr_sel = 1'b1; o.mem_cmd = MEM_RD; end
      S_IF2:   begin o.addr_sel = 1'b1; o.mem_cmd = MEM_RD; o.load_ir = 1'b1; end
      S_UPC:   o.load_pc = 1'b1;
      S_MOVI:  begin o.vsel = VSEL_IMM; o.write = 1'b1; o.nsel = NSEL_RN; end
      S_GETB:  begin o.loadb = 1'b1; o.nsel = NSEL_RM; end
      S_GETA:  begin o.loada = 1'b1; o.nsel = NSEL_RN; end
      S_ALU:   o.loadc = 1'b1;
      S_ALUZ:  begin o.asel = 1'b1; o.loadc = 1'b1; end
      S_CMP:   o.loads = 1'b1;
      S_WB:    begin o.vsel = VSEL_C; o.write = 1'b1; o.nsel = NSEL_RD; end
      S_ADDR:  begin o.bsel = 1'b1; o.loadc = 1'b1; end
      S_LADDR: o.load_addr = 1'b1;
      S_MRD:   begin o.addr_sel = 1'b0; o.mem_cmd = MEM_RD; end
      S_LDWB:  begin
        o.mem_cmd = MEM_RD;
        o.vsel    = VSEL_MDATA;
        o.write   = 1'b1;
        o.nsel    = NSEL_RD;
      end
      S_STB:   begin o.loadb = 1'b1; o.nsel = NSEL_RD; end
      S_STC:   begin o.asel = 1'b1; o.loadc = 1'b1; end
      S_MWR:   o.mem_cmd = MEM_WR;
      S_HALT:  begin o.w = 1'b1; o.halted = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cpu_control_seq_if.sv
// Controller <-> datapath/memory strobe bundle. The controller is the master;
// the datapath side (and any bench) connects through the slave modport.
interface cpu_control_seq_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [1:0] vsel;
  logic       write;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic [2:0] nsel;
  logic       load_ir;
  logic       load_pc;
  logic       reset_pc;
  logic       addr_sel;
  logic       load_addr;
  logic [1:0] mem_cmd;
  logic       w;
  logic       illegal;
  logic       halted;

  modport master (
    input  s, opcode, op,
    output vsel, write, loada, loadb, loadc, loads, asel, bsel, nsel,
    output load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd,
    output w, illegal, halted
  );

  modport slave (
    output s, opcode, op,
    input  vsel, write, loada, loadb, loadc, loads, asel, bsel, nsel,
    input  load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd,
    input  w, illegal, halted
  );
endinterface

// File: rtl/cpu_control_seq_lat_cnt.sv
// Memory-wait down-counter: load a start value, count down to zero and hold,
// with a registered zero flag so the sequencer sees a clean exit condition.
module ctrl_lat_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic             zero_r;

  // Next count: load wins over decrement; saturate at zero.
  always_comb begin
    cnt_nx_s = cnt_r;
    if (load) begin
      cnt_nx_s = load_val;
    end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_nx_s = cnt_r - CNT_W'(1);
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // Count and zero flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CNT_W{1'b0}};
      zero_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_nx_s;
      zero_r <= (cnt_nx_s == {CNT_W{1'b0}});
    end
  end

  assign zero = zero_r;

endmodule

// File: rtl/cpu_control_seq.sv
// Simple RISC Machine control sequencer: fetch, decode and execute of MOV, ALU,
// LDR/STR and HALT. Outputs are flops loaded with the decode of the next state.
module cpu_control_seq #(
  parameter int MEM_LAT    = 1,
  parameter int AUTO_FETCH = 1,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  cpu_control_seq_if.master bus
);
  import cpu_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(MEM_LAT - 1);
  localparam state_t           RESTART_ST = (AUTO_FETCH != 0) ? S_IF1 : S_WAIT;

  state_t    state_r;
  state_t    state_nx_s;
  ctrl_out_t out_r;
  logic      illegal_r;
  logic      lat_load_s;
  logic      lat_dec_s;
  logic      lat_zero_s;

  ctrl_lat_cnt #(.CNT_W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (lat_load_s),
    .dec      (lat_dec_s),
    .load_val (LAT_INIT),
    .zero     (lat_zero_s)
  );

  // Counter is armed on the edge that enters a wait state, then runs down inside it.
  always_comb begin
    lat_load_s = ((state_nx_s == S_IF1) && (state_r != S_IF1)) ||
                 ((state_nx_s == S_MRD) && (state_r != S_MRD));
    lat_dec_s  = (state_r == S_IF1) || (state_r == S_MRD);
  end

  // Next-state logic; corrupted encodings recover through S_RST.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_RST:   state_nx_s = RESTART_ST;
      S_WAIT:  begin
        if (bus.s) state_nx_s = S_IF1;
        else       state_nx_s = S_WAIT;
      end
      S_IF1:   begin
        if (lat_zero_s) state_nx_s = S_IF2;
        else            state_nx_s = S_IF1;
      end
      S_IF2:   state_nx_s = S_UPC;
      S_UPC:   state_nx_s = S_DEC;
      S_DEC:   state_nx_s = dec_next(bus.opcode, bus.op);
      S_MOVI:  state_nx_s = S_DONE;
      S_GETB:  begin
        if ((bus.opcode == OPC_MOV) || ((bus.opcode == OPC_ALU) && (bus.op == OP_MVN)))
          state_nx_s = S_ALUZ;
        else
          state_nx_s = S_GETA;
      end
      S_GETA:  begin
        if (bus.opcode == OPC_ALU) begin
          case (bus.op)
            OP_ADD, OP_AND: state_nx_s = S_ALU;
            OP_CMP:         state_nx_s = S_CMP;
            default:        state_nx_s = S_DONE;
          endcase
        end else if ((bus.opcode == OPC_LDR) || (bus.opcode == OPC_STR)) begin
          state_nx_s = S_ADDR;
        end else begin
          state_nx_s = S_DONE;
        end
      end
      S_ALU:   state_nx_s = S_WB;
      S_ALUZ:  state_nx_s = S_WB;
      S_CMP:   state_nx_s = S_DONE;
      S_WB:    state_nx_s = S_DONE;
      S_ADDR:  state_nx_s = S_LADDR;
      S_LADDR: begin
        if (bus.opcode == OPC_LDR) state_nx_s = S_MRD;
        else                       state_nx_s = S_STB;
      end
      S_MRD:   begin
        if (lat_zero_s) state_nx_s = S_LDWB;
        else            state_nx_s = S_MRD;
      end
      S_LDWB:  state_nx_s = S_DONE;
      S_STB:   state_nx_s = S_STC;
      S_STC:   state_nx_s = S_MWR;
      S_MWR:   state_nx_s = S_DONE;
      S_DONE:  state_nx_s = RESTART_ST;
      S_HALT:  state_nx_s = S_HALT;
      default: state_nx_s = S_RST;
    endcase
  end

  // State and output registers; the IR is stable from S_UPC on, so the illegal
  // flag is resolved one edge early and lines up with the S_DEC cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_RST;
      out_r     <= state_outputs(S_RST);
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      out_r     <= state_outputs(state_nx_s);
      illegal_r <= (state_nx_s == S_DEC) && is_illegal(bus.opcode, bus.op);
    end
  end

  assign bus.vsel      = out_r.vsel;
  assign bus.write     = out_r.write;
  assign bus.loada     = out_r.loada;
  assign bus.loadb     = out_r.loadb;
  assign bus.loadc     = out_r.loadc;
  assign bus.loads     = out_r.loads;
  assign bus.asel      = out_r.asel;
  assign bus.bsel      = out_r.bsel;
  assign bus.nsel      = out_r.nsel;
  assign bus.load_ir   = out_r.load_ir;
  assign bus.load_pc   = out_r.load_pc;
  assign bus.reset_pc  = out_r.reset_pc;
  assign bus.addr_sel  = out_r.addr_sel;
  assign bus.load_addr = out_r.load_addr;
  assign bus.mem_cmd   = out_r.mem_cmd;
  assign bus.w         = out_r.w;
  assign bus.halted    = out_r.halted;
  assign bus.illegal   = illegal_r;

endmodule

// File: tb/tb_cpu_control_seq.sv
// Scoreboard bench: a free-running instance (AUTO_FETCH=1, MEM_LAT=1) and a
// handshake instance (AUTO_FETCH=0, MEM_LAT=3), compared cycle by cycle.
module tb_cpu_control_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  localparam int LAT_B = 3;

  localparam logic [21:0] M_W    = 22'd1 << 21;
  localparam logic [21:0] M_HLT  = 22'd1 << 20;
  localparam logic [21:0] M_ILL  = 22'd1 << 19;
  localparam logic [21:0] MC_RD  = 22'd1 << 17;
  localparam logic [21:0] MC_WR  = 22'd2 << 17;
  localparam logic [21:0] M_AS   = 22'd1 << 16;
  localparam logic [21:0] M_LAD  = 22'd1 << 15;
  localparam logic [21:0] M_LIR  = 22'd1 << 14;
  localparam logic [21:0] M_LPC  = 22'd1 << 13;
  localparam logic [21:0] M_RPC  = 22'd1 << 12;
  localparam logic [21:0] VS_IMM = 22'd2 << 10;
  localparam logic [21:0] VS_MD  = 22'd3 << 10;
  localparam logic [21:0] M_WR   = 22'd1 << 9;
  localparam logic [21:0] M_LA   = 22'd1 << 8;
  localparam logic [21:0] M_LB   = 22'd1 << 7;
  localparam logic [21:0] M_LC   = 22'd1 << 6;
  localparam logic [21:0] M_LS   = 22'd1 << 5;
  localparam logic [21:0] M_ASEL = 22'd1 << 4;
  localparam logic [21:0] M_BSEL = 22'd1 << 3;
  localparam logic [21:0] N_RN   = 22'd4;
  localparam logic [21:0] N_RD   = 22'd2;
  localparam logic [21:0] N_RM   = 22'd1;
  localparam logic [21:0] NONE   = 22'd0;

  cpu_control_seq_if bus_a ();
  cpu_control_seq_if bus_b ();

  cpu_control_seq #(.MEM_LAT(1), .AUTO_FETCH(1), .CNT_W(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.master)
  );

  cpu_control_seq #(.MEM_LAT(LAT_B), .AUTO_FETCH(0), .CNT_W(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.master)
  );

  logic [21:0] obs_a;
  logic [21:0] obs_b;
  assign obs_a = {bus_a.w, bus_a.halted, bus_a.illegal, bus_a.mem_cmd, bus_a.addr_sel,
                  bus_a.load_addr, bus_a.load_ir, bus_a.load_pc, bus_a.reset_pc, bus_a.vsel,
                  bus_a.write, bus_a.loada, bus_a.loadb, bus_a.loadc, bus_a.loads,
                  bus_a.asel, bus_a.bsel, bus_a.nsel};
  assign obs_b = {bus_b.w, bus_b.halted, bus_b.illegal, bus_b.mem_cmd, bus_b.addr_sel,
                  bus_b.load_addr, bus_b.load_ir, bus_b.load_pc, bus_b.reset_pc, bus_b.vsel,
                  bus_b.write, bus_b.loada, bus_b.loadb, bus_b.loadc, bus_b.loads,
                  bus_b.asel, bus_b.bsel, bus_b.nsel};

  logic [21:0] q_a[$];
  logic [21:0] q_b[$];

  task automatic check_val(input string tag, input logic [21:0] got, input logic [21:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One compare per queued vector per cycle, sampled at the falling edge.
  task automatic drain(input string tag, input bit toggle_s, input int max_steps);
    int step;
    step = 0;
    while (((q_a.size() != 0) || (q_b.size() != 0)) && (step < max_steps)) begin
      @(posedge clk);
      @(negedge clk);
      if (toggle_s) bus_b.s = ~bus_b.s;
      else          bus_b.s = 1'b0;
      if (q_a.size() != 0) check_val($sformatf("%s_a%0d", tag, step), obs_a, q_a.pop_front());
      if (q_b.size() != 0) check_val($sformatf("%s_b%0d", tag, step), obs_b, q_b.pop_front());
      step++;
    end
  endtask

  // Expected per-cycle trace for one instruction on the handshake instance.
  task automatic push_b(input logic [2:0] opc, input logic [1:0] opv);
    for (int i = 0; i < LAT_B; i++) q_b.push_back(MC_RD | M_AS);
    q_b.push_back(MC_RD | M_AS | M_LIR);
    q_b.push_back(M_LPC);
    case (opc)
      3'b110: begin
        if (opv == 2'b10) begin
          q_b.push_back(NONE);
          q_b.push_back(VS_IMM | M_WR | N_RN);
        end else if (opv == 2'b00) begin
          q_b.push_back(NONE);
          q_b.push_back(M_LB | N_RM);
          q_b.push_back(M_ASEL | M_LC);
          q_b.push_back(M_WR | N_RD);
        end else begin
          q_b.push_back(M_ILL);
        end
      end
      3'b101: begin
        q_b.push_back(NONE);
        q_b.push_back(M_LB | N_RM);
        if (opv == 2'b11) begin
          q_b.push_back(M_ASEL | M_LC);
          q_b.push_back(M_WR | N_RD);
        end else begin
          q_b.push_back(M_LA | N_RN);
          if (opv == 2'b01) begin
            q_b.push_back(M_LS);
          end else begin
            q_b.push_back(M_LC);
            q_b.push_back(M_WR | N_RD);
          end
        end
      end
      3'b011: begin
        q_b.push_back(NONE);
        q_b.push_back(M_LA | N_RN);
        q_b.push_back(M_BSEL | M_LC);
        q_b.push_back(M_LAD);
        for (int i = 0; i < LAT_B; i++) q_b.push_back(MC_RD);
        q_b.push_back(MC_RD | VS_MD | M_WR | N_RD);
      end
      3'b100: begin
        q_b.push_back(NONE);
        q_b.push_back(M_LA | N_RN);
        q_b.push_back(M_BSEL | M_LC);
        q_b.push_back(M_LAD);
        q_b.push_back(M_LB | N_RD);
        q_b.push_back(M_ASEL | M_LC);
        q_b.push_back(MC_WR);
      end
      3'b111: begin
        q_b.push_back(NONE);
        for (int i = 0; i < 20; i++) q_b.push_back(M_W | M_HLT);
      end
      default: q_b.push_back(M_ILL);
    endcase
    if (opc != 3'b111) begin
      q_b.push_back(NONE);
      q_b.push_back(M_W);
    end
  endtask

  task automatic start_b(input logic [2:0] opc, input logic [1:0] opv);
    bus_b.opcode = opc;
    bus_b.op     = opv;
    bus_b.s      = 1'b1;
    push_b(opc, opv);
  endtask

  logic [2:0] opc_tab [10] = '{3'b110, 3'b101, 3'b101, 3'b101, 3'b101,
                               3'b110, 3'b011, 3'b100, 3'b000, 3'b110};
  logic [1:0] op_tab  [10] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b11,
                               2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

  initial begin
    bus_a.s = 1'b0; bus_a.opcode = 3'b110; bus_a.op = 2'b00;
    bus_b.s = 1'b0; bus_b.opcode = 3'b000; bus_b.op = 2'b00;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_a", obs_a, M_RPC | M_LPC);
    check_val("rst_b", obs_b, M_RPC | M_LPC);
    reset = 1'b1;
    #1;
    check_val("rel_a_c0", obs_a, M_RPC | M_LPC);

    // Free-running fetch of a MOV Rd,Rm, then straight back to fetch.
    q_a.push_back(MC_RD | M_AS);
    q_a.push_back(MC_RD | M_AS | M_LIR);
    q_a.push_back(M_LPC);
    q_a.push_back(NONE);
    q_a.push_back(M_LB | N_RM);
    q_a.push_back(M_ASEL | M_LC);
    q_a.push_back(M_WR | N_RD);
    q_a.push_back(NONE);
    q_a.push_back(MC_RD | M_AS);
    q_b.push_back(M_W);
    drain("boot", 1'b0, 1000);

    for (int k = 0; k < 10; k++) begin
      start_b(opc_tab[k], op_tab[k]);
      drain($sformatf("ins%0d", k), 1'b0, 1000);
    end

    // LDR interrupted by reset while the memory read is outstanding.
    start_b(3'b011, 2'b00);
    drain("ldr_int", 1'b0, 10);
    #2;
    reset = 1'b0;
    #1;
    check_val("rst_mrd_memcmd", {20'd0, bus_b.mem_cmd}, NONE);
    check_val("rst_mrd_out", obs_b, M_RPC | M_LPC);
    q_b.delete();
    q_a.delete();
    @(negedge clk);
    check_val("rst_mrd_hold", obs_b, M_RPC | M_LPC);
    reset = 1'b1;
    q_b.push_back(M_W);
    drain("rst_rel", 1'b0, 1000);

    // HALT: absorbing even with s toggling.
    start_b(3'b111, 2'b00);
    drain("halt", 1'b1, 1000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
